// File: rtl/dma_write_controller_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : dma_write_controller_if                                     |
// | Purpose  : Device command, CPU bus-grant and data-memory write signals |
// |            shared by the DMA write controller and its environment.     |
// | Revision : 1.0                                                         |
// +------------------------------------------------------------------------+
interface dma_write_controller_if #(
  parameter int WORD_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int TOTAL_LEN = 12
);
  logic                        dma_begin;
  logic [ADDR_W-1:0]           dma_base_addr;
  logic [WORD_W*TOTAL_LEN-1:0] dev_data;
  logic                        BG;
  logic                        BR;
  logic                        mem_ready;
  logic                        mem_write;
  logic [ADDR_W-1:0]           mem_addr;
  logic [WORD_W-1:0]           mem_data;
  logic                        dma_end;

  modport master (
    input  dma_begin, dma_base_addr, dev_data, BG, mem_ready,
    output BR, mem_write, mem_addr, mem_data, dma_end
  );

  modport slave (
    output dma_begin, dma_base_addr, dev_data, BG, mem_ready,
    input  BR, mem_write, mem_addr, mem_data, dma_end
  );
endinterface
`default_nettype wire

// File: rtl/dma_write_controller.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : dma_write_controller                                        |
// | Purpose  : Bus-master side of the BR/BG handshake; writes a block of   |
// |            device words into data memory and pulses dma_end.           |
// | Options  : CYCLE_STEALING_EN - release the bus between bursts.         |
// | Revision : 1.0                                                         |
// +------------------------------------------------------------------------+
module dma_write_controller #(
  parameter int WORD_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int TOTAL_LEN = 12,
  parameter int BURST_LEN = 4
) (
  input  wire logic              clk,
  input  wire logic              reset_n,
  dma_write_controller_if.master bus
);

  localparam int                 c_cnt_w = (TOTAL_LEN > 1) ? $clog2(TOTAL_LEN) : 1;
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(TOTAL_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_REQ      = 3'd1,
    S_XFER     = 3'd2,
    S_REL      = 3'd3,
    S_DONE     = 3'd4,
    S_GAP      = 3'd5,
    S_GAP_IDLE = 3'd6
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [ADDR_W-1:0]   r_base;
  logic [ADDR_W-1:0]   w_next_base;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [c_cnt_w-1:0]  w_next_cnt;

  logic                r_br;
  logic                r_mem_write;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [WORD_W-1:0]   r_mem_data;
  logic                r_dma_end;

  logic                w_accept;
  logic                w_last;
  logic                w_br_next;
  logic                w_write_next;
  logic [ADDR_W-1:0]   w_addr_next;
  logic [WORD_W-1:0]   w_data_next;

  // A word is consumed only when the strobe was out and memory took it.
  assign w_accept = r_mem_write && bus.mem_ready;
  assign w_last   = (r_cnt == c_last);

`ifdef CYCLE_STEALING_EN
  localparam int                   c_burst_w    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [c_burst_w-1:0] c_burst_last = c_burst_w'(BURST_LEN - 1);

  logic [c_burst_w-1:0] r_burst_cnt;
  logic                 w_burst_last;

  assign w_burst_last = (r_burst_cnt == c_burst_last);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_burst_cnt <= '0;
    end else if (r_state == S_IDLE) begin
      r_burst_cnt <= '0;
    end else if ((r_state == S_XFER) && w_accept) begin
      r_burst_cnt <= w_burst_last ? '0 : r_burst_cnt + c_burst_w'(1);
    end
  end
`endif

  always_comb begin
    w_next_state = r_state;
    w_next_base  = r_base;
    w_next_cnt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (bus.dma_begin) begin
          w_next_state = S_REQ;
          w_next_base  = bus.dma_base_addr;
          w_next_cnt   = '0;
        end
      end
      S_REQ: begin
        if (bus.BG) w_next_state = S_XFER;
      end
      S_XFER: begin
        if (w_accept) begin
          if (w_last) begin
            w_next_state = S_REL;
          end else begin
            w_next_cnt = r_cnt + c_cnt_w'(1);
`ifdef CYCLE_STEALING_EN
            if (w_burst_last) w_next_state = S_GAP;
`endif
          end
        end
      end
      S_REL: begin
        if (!bus.BG) w_next_state = S_DONE;
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      S_GAP: begin
        if (!bus.BG) w_next_state = S_GAP_IDLE;
      end
      S_GAP_IDLE: begin
        w_next_state = S_REQ;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Outputs are precomputed from the next state so every port is a flop.
  assign w_br_next    = (w_next_state == S_REQ) || (w_next_state == S_XFER);
  assign w_write_next = (w_next_state == S_XFER) && bus.BG;
  assign w_addr_next  = w_write_next ? (w_next_base + ADDR_W'(w_next_cnt)) : '0;
  assign w_data_next  = w_write_next ? bus.dev_data[int'(w_next_cnt) * WORD_W +: WORD_W] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_base      <= '0;
      r_cnt       <= '0;
      r_br        <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_data  <= '0;
      r_dma_end   <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_base      <= w_next_base;
      r_cnt       <= w_next_cnt;
      r_br        <= w_br_next;
      r_mem_write <= w_write_next;
      r_mem_addr  <= w_addr_next;
      r_mem_data  <= w_data_next;
      r_dma_end   <= (w_next_state == S_DONE);
    end
  end

  assign bus.BR        = r_br;
  assign bus.mem_write = r_mem_write;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_data  = r_mem_data;
  assign bus.dma_end   = r_dma_end;

endmodule
`default_nettype wire

// File: tb/tb_dma_write_controller.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_dma_write_controller                                     |
// | Purpose  : Directed vector bench for dma_write_controller with a       |
// |            delayed-grant CPU model and a write-stream scoreboard.      |
// | Revision : 1.0                                                         |
// +------------------------------------------------------------------------+
module tb_dma_write_controller;

  localparam int WORD_W    = 16;
  localparam int ADDR_W    = 16;
  localparam int TOTAL_LEN = 12;
  localparam int BURST_LEN = 4;

`ifdef CYCLE_STEALING_EN
  localparam int c_exp_rises = TOTAL_LEN / BURST_LEN;
  localparam int c_steal     = 1;
`else
  localparam int c_exp_rises = 1;
  localparam int c_steal     = 0;
`endif

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  dma_write_controller_if #(.WORD_W(WORD_W), .ADDR_W(ADDR_W), .TOTAL_LEN(TOTAL_LEN)) bus ();

  dma_write_controller #(
    .WORD_W(WORD_W), .ADDR_W(ADDR_W), .TOTAL_LEN(TOTAL_LEN), .BURST_LEN(BURST_LEN)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  typedef struct {
    logic [15:0] base;
    logic [15:0] seed;
    int          stall_lo;
    int          stall_hi;
    int          drop_at;
    bit          extra_begin;
    int          exp_wr;
    int          exp_br;
    logic [15:0] exp_addr6;
    logic [15:0] exp_last_addr;
    logic [15:0] exp_last_data;
  } vec_t;

  vec_t vecs [4];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Configuration written by the stimulus process, read by the monitor
  logic [15:0] exp_base;
  logic [15:0] seed;
  int          stall_lo = 0;
  int          stall_hi = 0;
  int          drop_at  = 0;
  int          clr_gen  = 0;

  // Observations written only by the monitor
  int          clr_seen = 0;
  int          br_cycles, br_rises, end_cnt, end_cyc, wr_cycles, first_wr_cyc;
  int          n_acc, last_acc_cyc, wr_bad, gap_bg_low, drop_left;
  logic [15:0] acc_addr [16];
  logic [15:0] acc_data [16];
  int          acc_cyc  [16];
  logic        br_prev_m = 1'b0;
  logic        bg_pipe   = 1'b0;

  // Monitor, memory-ready pattern and CPU grant model (grant follows BR one cycle late)
  always @(negedge clk) begin
    logic ready;
    if (clr_seen != clr_gen) begin
      clr_seen     = clr_gen;
      br_cycles    = 0;
      br_rises     = 0;
      end_cnt      = 0;
      end_cyc      = -1000;
      wr_cycles    = 0;
      first_wr_cyc = -1000;
      n_acc        = 0;
      last_acc_cyc = -1000;
      wr_bad       = 0;
      gap_bg_low   = 0;
      drop_left    = 0;
      for (int i = 0; i < 16; i++) begin
        acc_addr[i] = 16'hxxxx;
        acc_data[i] = 16'hxxxx;
        acc_cyc[i]  = -1000;
      end
    end
    ready = 1'b1;
    if (bus.BR === 1'b1) br_cycles++;
    if (bus.BR === 1'b1 && br_prev_m !== 1'b1) br_rises++;
    br_prev_m = bus.BR;
    if (bus.dma_end === 1'b1) begin
      end_cnt++;
      end_cyc = cyc;
    end
    if (n_acc > 0 && n_acc < TOTAL_LEN && bus.BR === 1'b0 && bus.BG === 1'b0) gap_bg_low++;
    if (bus.mem_write === 1'b1) begin
      wr_cycles++;
      if (wr_cycles == 1) first_wr_cyc = cyc;
      if (n_acc >= TOTAL_LEN || bus.mem_addr !== 16'(exp_base + 16'(n_acc))
          || bus.mem_data !== 16'(seed + 16'(n_acc))) begin
        wr_bad++;
      end
      ready = !(stall_lo > 0 && wr_cycles >= stall_lo && wr_cycles <= stall_hi);
      if (ready) begin
        if (n_acc < 16) begin
          acc_addr[n_acc] = bus.mem_addr;
          acc_data[n_acc] = bus.mem_data;
          acc_cyc[n_acc]  = cyc;
        end
        n_acc++;
        last_acc_cyc = cyc;
        if (drop_at > 0 && n_acc == drop_at) drop_left = 2;
      end
    end
    bus.mem_ready = ready;
    if (drop_left > 0) begin
      bus.BG = 1'b0;
      drop_left--;
    end else begin
      bus.BG = bg_pipe;
    end
    bg_pipe = bus.BR;
  end

  int n_vec = 0;
  int n_err = 0;
  int begin_cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    clr_gen++;
    @(negedge clk);
    #1;
  endtask

  task automatic load_buffer(input logic [15:0] b, input logic [15:0] s);
    exp_base = b;
    seed     = s;
    for (int i = 0; i < TOTAL_LEN; i++) bus.dev_data[i*WORD_W +: WORD_W] = s + 16'(i);
    bus.dma_base_addr = b;
  endtask

  task automatic pulse_begin();
    bus.dma_begin = 1'b1;
    begin_cyc     = cyc;
    @(negedge clk);
    #1;
    bus.dma_begin = 1'b0;
  endtask

  task automatic run_vec(input int k);
    vec_t v;
    v        = vecs[k];
    stall_lo = v.stall_lo;
    stall_hi = v.stall_hi;
    drop_at  = v.drop_at;
    load_buffer(v.base, v.seed);
    clear_mon();
    pulse_begin();
    if (v.extra_begin) begin
      for (int i = 0; i < 100 && wr_cycles < 2; i++) @(posedge clk);
      #2;
      bus.dma_base_addr = 16'h0500;
      bus.dma_begin     = 1'b1;
      @(posedge clk);
      #2;
      bus.dma_begin     = 1'b0;
    end
    for (int i = 0; i < 300 && end_cnt == 0; i++) @(posedge clk);
    repeat (8) @(posedge clk);
    #2;
    chk($sformatf("v%0d accepted", k), n_acc, TOTAL_LEN);
    chk($sformatf("v%0d write_cycles", k), wr_cycles, v.exp_wr);
    chk($sformatf("v%0d bad_writes", k), wr_bad, 0);
    chk($sformatf("v%0d addr6", k), acc_addr[6], v.exp_addr6);
    chk($sformatf("v%0d last_addr", k), acc_addr[TOTAL_LEN-1], v.exp_last_addr);
    chk($sformatf("v%0d last_data", k), acc_data[TOTAL_LEN-1], v.exp_last_data);
    chk($sformatf("v%0d first_write_lat", k), first_wr_cyc - begin_cyc, 3);
    chk($sformatf("v%0d end_lat", k), end_cyc - last_acc_cyc, 3);
    chk($sformatf("v%0d dma_end_count", k), end_cnt, 1);
    chk($sformatf("v%0d br_rises", k), br_rises, c_exp_rises);
    chk($sformatf("v%0d gap_bg_low", k), 32'(gap_bg_low > 0), c_steal);
`ifndef CYCLE_STEALING_EN
    chk($sformatf("v%0d br_cycles", k), br_cycles, v.exp_br);
`endif
    if (v.drop_at > 0)
      chk($sformatf("v%0d resume_gap", k), acc_cyc[v.drop_at] - acc_cyc[v.drop_at-1], 3);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{base: 16'h0010, seed: 16'hA000, stall_lo: 0, stall_hi: 0, drop_at: 0, extra_begin: 1'b0,
                exp_wr: 12, exp_br: 14, exp_addr6: 16'h0016, exp_last_addr: 16'h001B, exp_last_data: 16'hA00B};
    vecs[1] = '{base: 16'h0010, seed: 16'hA000, stall_lo: 3, stall_hi: 4, drop_at: 0, extra_begin: 1'b0,
                exp_wr: 14, exp_br: 16, exp_addr6: 16'h0016, exp_last_addr: 16'h001B, exp_last_data: 16'hA00B};
    vecs[2] = '{base: 16'hFFFA, seed: 16'h5000, stall_lo: 0, stall_hi: 0, drop_at: 0, extra_begin: 1'b0,
                exp_wr: 12, exp_br: 14, exp_addr6: 16'h0000, exp_last_addr: 16'h0005, exp_last_data: 16'h500B};
    vecs[3] = '{base: 16'h0010, seed: 16'hC000, stall_lo: 0, stall_hi: 0, drop_at: 6, extra_begin: 1'b1,
                exp_wr: 12, exp_br: 16, exp_addr6: 16'h0016, exp_last_addr: 16'h001B, exp_last_data: 16'hC00B};

    reset_n           = 1'b0;
    bus.dma_begin     = 1'b0;
    bus.dma_base_addr = '0;
    bus.dev_data      = '0;
    repeat (3) @(negedge clk);
    chk("reset BR", bus.BR, 0);
    chk("reset mem_write", bus.mem_write, 0);
    chk("reset mem_addr", bus.mem_addr, 0);
    chk("reset mem_data", bus.mem_data, 0);
    chk("reset dma_end", bus.dma_end, 0);
    #1;
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;

    for (int k = 0; k < 4; k++) run_vec(k);

    // Asynchronous reset in the middle of a transfer
    stall_lo = 0;
    drop_at  = 0;
    load_buffer(16'h0100, 16'h3000);
    clear_mon();
    pulse_begin();
    for (int i = 0; i < 100 && n_acc < 5; i++) @(posedge clk);
    #2;
    chk("rst accepted_before", n_acc, 5);
    chk("rst mem_write_before", bus.mem_write, 1);
    reset_n = 1'b0;
    #1;
    chk("rst async BR", bus.BR, 0);
    chk("rst async mem_write", bus.mem_write, 0);
    chk("rst async dma_end", bus.dma_end, 0);
    chk("rst async mem_addr", bus.mem_addr, 0);
    repeat (2) @(negedge clk);
    clear_mon();
    reset_n = 1'b1;
    repeat (15) @(posedge clk);
    #2;
    chk("post_rst dma_end_count", end_cnt, 0);
    chk("post_rst br_cycles", br_cycles, 0);
    @(negedge clk);
    #1;
    run_vec(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
